// File: rtl/idc_pkg.sv
// Shared constants and types for the IDC frame packer: pixel, row-word and frame-sum widths.
package idc_pkg;

    localparam int PIX_W     = 7;
    localparam int FRAME_PIX = 16;
    localparam int ROW_PIX   = 4;
    localparam int ROW_W     = PIX_W * ROW_PIX;
    localparam int SUM_W     = 11;
    localparam int IDX_W     = $clog2(FRAME_PIX);
    localparam int ROW_IDX_W = $clog2(FRAME_PIX / ROW_PIX);

    typedef logic [PIX_W-1:0]     pix_t;
    typedef logic [ROW_W-1:0]     row_t;
    typedef logic [SUM_W-1:0]     sum_t;
    typedef logic [IDX_W-1:0]     pix_idx_t;
    typedef logic [ROW_IDX_W-1:0] row_idx_t;

    localparam pix_idx_t LAST_PIX = pix_idx_t'(FRAME_PIX - 1);
    localparam row_idx_t LAST_ROW = row_idx_t'(FRAME_PIX / ROW_PIX - 1);

endpackage

// File: rtl/idc_frame_bank.sv
// One frame buffer: 16 pixel registers, running pixel sum, full flag and a row read mux.
module idc_frame_bank
    import idc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_en_i,
    input  pix_idx_t wr_idx_i,
    input  pix_t     wr_data_i,
    input  logic     set_full_i,
    input  logic     clr_full_i,
    input  row_idx_t rd_row_i,
    output row_t     rd_data_o,
    output sum_t     sum_o,
    output logic     full_o
);

    pix_t mem_q [FRAME_PIX];
    sum_t sum_q;
    logic full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FRAME_PIX; i++) begin
                mem_q[i] <= '0;
            end
            sum_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_idx_i] <= wr_data_i;
                // Pixel 0 restarts the sum, so no explicit clear is needed on free.
                sum_q <= (wr_idx_i == '0) ? sum_t'(wr_data_i) : sum_q + sum_t'(wr_data_i);
            end
            if (set_full_i) begin
                full_q <= 1'b1;
            end else if (clr_full_i) begin
                full_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < ROW_PIX; k++) begin
            rd_data_o[k*PIX_W +: PIX_W] = mem_q[{rd_row_i, 2'(k)}];
        end
    end

    assign sum_o  = sum_q;
    assign full_o = full_q;

endmodule

// File: rtl/idc_frame_packer.sv
// Captures 16-pixel IDC frames into a ping-pong buffer and replays them as four row words
// with the frame sum; a frame arriving while its target bank is still full is dropped.
module idc_frame_packer
    import idc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ROW_W-1:0] m_data,
    output logic             m_last,
    output logic [SUM_W-1:0] m_sum,
    output logic             overflow
);

    pix_idx_t pix_cnt_q, pix_cnt_d;
    row_idx_t rd_row_q, rd_row_d;
    logic     drop_q, drop_d;
    logic     wr_bank_q, wr_bank_d;
    logic     rd_bank_q, rd_bank_d;
    logic     m_valid_q, m_valid_d;
    logic     overflow_q, overflow_d;

    logic [1:0] full, full_nxt, wr_en, set_full, clr_full;
    logic       frame_drop, fire, fire_last;
    row_t       rd_data [2];
    sum_t       bank_sum [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        idc_frame_bank u_bank (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (wr_en[b]),
            .wr_idx_i   (pix_cnt_q),
            .wr_data_i  (in_data),
            .set_full_i (set_full[b]),
            .clr_full_i (clr_full[b]),
            .rd_row_i   (rd_row_q),
            .rd_data_o  (rd_data[b]),
            .sum_o      (bank_sum[b]),
            .full_o     (full[b])
        );
    end

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        rd_row_d   = rd_row_q;
        drop_d     = drop_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        overflow_d = overflow_q;
        wr_en      = '0;
        set_full   = '0;
        clr_full   = '0;

        // The drop decision is latched at pixel 0 and held for the whole frame.
        frame_drop = (pix_cnt_q == '0) ? full[wr_bank_q] : drop_q;
        fire       = m_valid_q && m_ready;
        fire_last  = fire && (rd_row_q == LAST_ROW);

        if (in_valid) begin
            pix_cnt_d = pix_cnt_q + pix_idx_t'(1);
            drop_d    = frame_drop;
            if (!frame_drop) begin
                wr_en[wr_bank_q] = 1'b1;
            end else if (pix_cnt_q == '0) begin
                overflow_d = 1'b1;
            end
            if (pix_cnt_q == LAST_PIX) begin
                pix_cnt_d = '0;
                if (!frame_drop) begin
                    set_full[wr_bank_q] = 1'b1;
                    wr_bank_d           = ~wr_bank_q;
                end
            end
        end

        if (fire) begin
            rd_row_d = rd_row_q + row_idx_t'(1);
        end
        if (fire_last) begin
            clr_full[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
        end

        // Look ahead at next-cycle bank state so valid appears one cycle after capture.
        full_nxt  = (full & ~clr_full) | set_full;
        m_valid_d = full_nxt[rd_bank_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_q  <= '0;
            rd_row_q   <= '0;
            drop_q     <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            rd_row_q   <= rd_row_d;
            drop_q     <= drop_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            m_valid_q  <= m_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_valid_q ? rd_data[rd_bank_q] : '0;
    assign m_last   = m_valid_q && (rd_row_q == LAST_ROW);
    assign m_sum    = m_valid_q ? bank_sum[rd_bank_q] : '0;
    assign overflow = overflow_q;

endmodule
